mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller directly downstream of instruction decode; consumes the decoded memory control bits (is_mem_op, is_load_op, is_store_op, is_byte_op) together with the effective address and store data.
- Runs a request/response handshake with data memory, stalls the pipeline while an access is outstanding, and forms byte-lane write masks for stores.
- Zero-extends LBU load data and returns load results with the destination register for register-file writeback.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits (fixed at 4 byte lanes)
- RD_W, 5, destination register index width
- TIMEOUT, 64, maximum cycles allowed in WAIT before the access is aborted

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_op_valid_i  in  1  current instruction is a memory op (decode is_mem_op); held stable while stall_o=1
- is_load_i  in  1  load (LW/LBU)
- is_store_i  in  1  store (SW/SB)
- is_byte_i  in  1  byte op (LBU/SB)
- addr_i  in  ADDR_W  effective address
- store_data_i  in  DATA_W  rt value for stores
- rd_i  in  RD_W  load destination register
- req_valid_o  out  1  memory request valid
- req_addr_o  out  ADDR_W  word-aligned address, bits[1:0]=0
- req_we_o  out  1  write enable
- req_mask_o  out  4  byte-lane write mask
- req_wdata_o  out  DATA_W  write data
- req_ready_i  in  1  memory accepts request this cycle
- resp_valid_i  in  1  memory response/ack valid
- resp_data_i  in  DATA_W  read data
- stall_o  out  1  freeze upstream stages
- wb_valid_o  out  1  load result valid, one-cycle pulse
- wb_rd_o  out  RD_W  writeback register
- wb_data_o  out  DATA_W  writeback data
- err_o  out  1  one-cycle pulse on misalignment or timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset goes to IDLE; all outputs 0; timeout counter 0.
- Reset asserted in any state, including mid-transaction, drops any outstanding request. A response arriving later is ignored.
- IDLE:
  - If mem_op_valid_i=1, capture addr, data, is_*, rd.
  - A misaligned word op (is_byte_i=0 and addr_i[1:0]!=0) goes to DONE with err pending and issues no memory request.
  - Any other memory op goes to REQ.
  - stall_o = mem_op_valid_i, combinational, in the same cycle.
- REQ:
  - Outputs: req_valid_o=1; req_addr_o = {addr[ADDR_W-1:2],2'b00}; req_we_o = store.
  - Word store: mask 4'hF, wdata = store_data.
  - SB: mask = 4'b0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
  - Loads: mask 4'hF, we=0.
  - Request fields stay stable until req_ready_i.
  - On req_ready_i: if resp_valid_i is also 1, go to DONE; otherwise go to WAIT.
  - stall_o=1.
- WAIT:
  - req_valid_o=0, stall_o=1; counter increments each cycle.
  - On resp_valid_i, latch the result and go to DONE.
  - On counter reaching TIMEOUT-1 with no response, go to DONE with err pending and no writeback.
  - Counter clears on leaving WAIT.
- Result formation:
  - LW: resp_data_i.
  - LBU: zero-extended resp_data_i[8*addr[1:0]+7 : 8*addr[1:0]].
  - Stores: the response is an ack only; no data is written back.
- DONE (exactly one cycle, then IDLE):
  - stall_o=0 so the pipeline advances.
  - wb_valid_o=1 only for a successful load, with wb_rd_o/wb_data_o driven.
  - err_o=1 if err is pending.
  - A new mem op is not accepted in DONE; the next instruction is sampled in IDLE on the following cycle.
- Minimum latency for an aligned access with ready and response in the same cycle:
  - IDLE to REQ to DONE, 2 stall cycles; writeback appears in cycle 3.
- resp_valid_i outside REQ/WAIT is ignored.
- Non-memory instructions (mem_op_valid_i=0) never stall and never produce a request.

Test Plan:
- LW addr=0x104, ready and resp same cycle, resp=0xDEADBEEF -> req_addr=0x104, mask=F, we=0; stall_o high 2 cycles; wb_valid pulse with wb_data=0xDEADBEEF and rd echoed.
- LBU addr=0x203, resp=0x11223344 after 3 WAIT cycles -> wb_data=0x00000011; stall_o high 5 cycles.
- SB addr=0x302, store_data=0xAABBCCDD -> req_addr=0x300, mask=4'b0100, wdata=0xDDDDDDDD, we=1; after ack, wb_valid stays 0.
- SW addr=0x106 (misaligned) -> no req_valid_o; err_o pulses in the DONE cycle; stall_o high 1 cycle.
- LW with no response, TIMEOUT=64 -> 64 WAIT cycles, then err_o pulse, wb_valid=0, FSM returns to IDLE.
- Reset asserted during WAIT, then a late resp_valid_i -> all outputs 0 next cycle; the late response is ignored; no wb_valid.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the memory-stage controller (master)
// and the data memory (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_we_o;
    logic [3:0]        req_mask_o;
    logic [DATA_W-1:0] req_wdata_o;
    logic              req_ready_i;
    logic              resp_valid_i;
    logic [DATA_W-1:0] resp_data_i;

    modport master (
        output req_valid_o, req_addr_o, req_we_o, req_mask_o, req_wdata_o,
        input  req_ready_i, resp_valid_i, resp_data_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, req_we_o, req_mask_o, req_wdata_o,
        output req_ready_i, resp_valid_i, resp_data_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one data-memory access per decoded memory op,
// stalls the pipeline while it is outstanding and returns load results for writeback.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_op_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              is_byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [RD_W-1:0]   rd_i,
    mem_access_ctrl_if.master mem,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              err_pend;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [RD_W-1:0]   rd_q;
    logic              is_load_q;
    logic              is_store_q;
    logic              is_byte_q;
    logic [DATA_W-1:0] rdata_q;

    logic misaligned;
    assign misaligned = !is_byte_i && (addr_i[1:0] != 2'b00);

    // LBU picks the addressed byte lane and zero-extends it; LW passes the word through.
    function automatic logic [DATA_W-1:0] load_format(input logic [DATA_W-1:0] d,
                                                      input logic is_byte,
                                                      input logic [1:0] off);
        logic [DATA_W-1:0] sh;
        sh = d >> {off, 3'b000};
        return is_byte ? {{(DATA_W-8){1'b0}}, sh[7:0]} : d;
    endfunction

    function automatic logic [3:0] lane_mask(input logic is_store, input logic is_byte,
                                             input logic [1:0] off);
        return (is_store && is_byte) ? (4'b0001 << off) : 4'hF;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            err_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op_valid_i) begin
                        err_pend <= misaligned;
                        state    <= misaligned ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem.req_ready_i) state <= mem.resp_valid_i ? DONE : WAIT;
                end
                WAIT: begin
                    if (mem.resp_valid_i) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        err_pend <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    err_pend <= 1'b0;
                end
            endcase
        end
    end

    // Operand and result holding registers; outputs are qualified by state, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_op_valid_i) begin
            addr_q     <= addr_i;
            sdata_q    <= store_data_i;
            rd_q       <= rd_i;
            is_load_q  <= is_load_i;
            is_store_q <= is_store_i;
            is_byte_q  <= is_byte_i;
        end
        if ((state == REQ && mem.req_ready_i && mem.resp_valid_i) ||
            (state == WAIT && mem.resp_valid_i)) begin
            rdata_q <= load_format(mem.resp_data_i, is_byte_q, addr_q[1:0]);
        end
    end

    always_comb begin
        mem.req_valid_o = 1'b0;
        mem.req_addr_o  = '0;
        mem.req_we_o    = 1'b0;
        mem.req_mask_o  = 4'h0;
        mem.req_wdata_o = '0;
        stall_o         = 1'b0;
        wb_valid_o      = 1'b0;
        wb_rd_o         = '0;
        wb_data_o       = '0;
        err_o           = 1'b0;
        case (state)
            IDLE: stall_o = mem_op_valid_i;
            REQ: begin
                stall_o         = 1'b1;
                mem.req_valid_o = 1'b1;
                mem.req_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.req_we_o    = is_store_q;
                mem.req_mask_o  = lane_mask(is_store_q, is_byte_q, addr_q[1:0]);
                mem.req_wdata_o = is_byte_q ? {(DATA_W/8){sdata_q[7:0]}} : sdata_q;
            end
            WAIT: stall_o = 1'b1;
            default: begin
                err_o = err_pend;
                if (is_load_q && !err_pend) begin
                    wb_valid_o = 1'b1;
                    wb_rd_o    = rd_q;
                    wb_data_o  = rdata_q;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops push expected requests,
// writebacks, errors and stall lengths; a monitor pops and compares them.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_op_valid_i, is_load_i, is_store_i, is_byte_i;
    logic [31:0] addr_i, store_data_i;
    logic [4:0]  rd_i;
    logic        stall_o, wb_valid_o, err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_W(5), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .mem_op_valid_i(mem_op_valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .is_byte_i(is_byte_i), .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .mem(mem_if.master),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t exp_req_q[$];
    wb_t  exp_wb_q[$];
    int   exp_err_q[$];
    int   exp_stall_q[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        total++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge.
    int stall_run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_if.req_valid_o) begin
                if (exp_req_q.size() == 0) unexpected("req");
                else begin
                    chk("req_addr", mem_if.req_addr_o, exp_req_q[0].addr);
                    chk("req_we", 32'(mem_if.req_we_o), 32'(exp_req_q[0].we));
                    chk("req_mask", 32'(mem_if.req_mask_o), 32'(exp_req_q[0].mask));
                    if (exp_req_q[0].chk_wdata)
                        chk("req_wdata", mem_if.req_wdata_o, exp_req_q[0].wdata);
                    if (mem_if.req_ready_i) void'(exp_req_q.pop_front());
                end
            end
            if (wb_valid_o) begin
                if (exp_wb_q.size() == 0) unexpected("wb_valid");
                else begin
                    wb_t w;
                    w = exp_wb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd_o), 32'(w.rd));
                    chk("wb_data", wb_data_o, w.data);
                end
            end
            if (err_o) begin
                if (exp_err_q.size() == 0) unexpected("err");
                else begin
                    total++;
                    passed++;
                    void'(exp_err_q.pop_front());
                end
            end
        end
        if (stall_o) stall_run++;
        else if (stall_run > 0) begin
            if (exp_stall_q.size() == 0) unexpected("stall_run");
            else chk("stall_len", 32'(stall_run), 32'(exp_stall_q.pop_front()));
            stall_run = 0;
        end
    end

    task automatic clear_inputs();
        mem_op_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
        addr_i = '0; store_data_i = '0; rd_i = '0;
        mem_if.req_ready_i = 1'b0; mem_if.resp_valid_i = 1'b0; mem_if.resp_data_i = '0;
    endtask

    // Cycle 0 is the IDLE cycle that samples the op; cycle stall_len is DONE.
    task automatic run_op(input logic ld, input logic st, input logic bt,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int ready_at, input int resp_at, input int stall_len,
                          input logic [31:0] rdata);
        for (int c = 0; c <= stall_len; c++) begin
            @(posedge clk); #1;
            mem_op_valid_i = (c < stall_len);
            is_load_i = ld; is_store_i = st; is_byte_i = bt;
            addr_i = a; store_data_i = d; rd_i = rd;
            mem_if.req_ready_i  = (c >= ready_at);
            mem_if.resp_valid_i = (c == resp_at);
            mem_if.resp_data_i  = (c == resp_at) ? rdata : 32'h0;
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'h0);
        chk({tag, "_req_valid"}, 32'(mem_if.req_valid_o), 32'h0);
        chk({tag, "_req_addr"}, mem_if.req_addr_o, 32'h0);
        chk({tag, "_req_mask"}, 32'(mem_if.req_mask_o), 32'h0);
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'h0);
        chk({tag, "_err"}, 32'(err_o), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // LW 0x104, ready and response together
        exp_req_q.push_back('{32'h104, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_wb_q.push_back('{5'd7, 32'hDEADBEEF});
        exp_stall_q.push_back(2);
        run_op(1, 0, 0, 32'h104, 32'h0, 5'd7, 1, 1, 2, 32'hDEADBEEF);

        // LBU 0x203, response in the third WAIT cycle
        exp_req_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_wb_q.push_back('{5'd9, 32'h00000011});
        exp_stall_q.push_back(5);
        run_op(1, 0, 1, 32'h203, 32'h0, 5'd9, 1, 4, 5, 32'h11223344);

        // LBU 0x200 picks lane 0
        exp_req_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_wb_q.push_back('{5'd3, 32'h00000044});
        exp_stall_q.push_back(2);
        run_op(1, 0, 1, 32'h200, 32'h0, 5'd3, 1, 1, 2, 32'h11223344);

        // SB 0x302: lane 2, data replicated, no writeback
        exp_req_q.push_back('{32'h300, 1'b1, 4'b0100, 32'hDDDDDDDD, 1'b1});
        exp_stall_q.push_back(2);
        run_op(0, 1, 1, 32'h302, 32'hAABBCCDD, 5'd0, 1, 1, 2, 32'h0);

        // SW 0x108 with ready held low for two REQ cycles
        exp_req_q.push_back('{32'h108, 1'b1, 4'hF, 32'h12345678, 1'b1});
        exp_stall_q.push_back(4);
        run_op(0, 1, 0, 32'h108, 32'h12345678, 5'd0, 3, 3, 4, 32'h0);

        // Misaligned SW 0x106: error, no request
        exp_err_q.push_back(1);
        exp_stall_q.push_back(1);
        run_op(0, 1, 0, 32'h106, 32'h55555555, 5'd0, 0, -1, 1, 32'h0);

        // LW 0x110 with no response: 64 WAIT cycles then error
        exp_req_q.push_back('{32'h110, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_err_q.push_back(1);
        exp_stall_q.push_back(66);
        run_op(1, 0, 0, 32'h110, 32'h0, 5'd12, 1, -1, 66, 32'h0);

        // Non-memory cycles with a stray response: no stall, request or writeback
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            addr_i = 32'h400; is_load_i = 1'b1; rd_i = 5'd2;
            mem_if.resp_valid_i = 1'b1; mem_if.resp_data_i = 32'hBAD0BAD0;
            #1;
            chk("nonmem_stall", 32'(stall_o), 32'h0);
            chk("nonmem_req_valid", 32'(mem_if.req_valid_o), 32'h0);
        end
        @(posedge clk); #1;
        clear_inputs();

        // LW 0x120, reset asserted during WAIT, late response afterwards
        exp_req_q.push_back('{32'h120, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_stall_q.push_back(4);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            mem_op_valid_i = (c < 3);
            is_load_i = 1'b1; addr_i = 32'h120; rd_i = 5'd4;
            mem_if.req_ready_i  = (c >= 1);
            reset = (c == 3);
            mem_if.resp_valid_i = (c == 5);
            mem_if.resp_data_i  = (c == 5) ? 32'h77777777 : 32'h0;
            if (c == 4) begin
                #1;
                check_all_zero("post_reset");
            end
        end
        @(posedge clk); #1;
        clear_inputs();

        // Normal LW after the aborted one
        exp_req_q.push_back('{32'h124, 1'b0, 4'hF, 32'h0, 1'b0});
        exp_wb_q.push_back('{5'd5, 32'hCAFEF00D});
        exp_stall_q.push_back(2);
        run_op(1, 0, 0, 32'h124, 32'h0, 5'd5, 1, 1, 2, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_drained", 32'(exp_req_q.size()), 32'h0);
        chk("wb_q_drained", 32'(exp_wb_q.size()), 32'h0);
        chk("err_q_drained", 32'(exp_err_q.size()), 32'h0);
        chk("stall_q_drained", 32'(exp_stall_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
